mc_controller: RTL and testbench
================================

# mc_controller

Multi-cycle successor to the single-cycle MIPS main controller. It decodes the same instruction subset, but sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives per-cycle datapath enables. Memory accesses use a req/ready handshake with an optional timeout. It sits between the instruction register and the shared multi-cycle datapath (PC, IR, register file, ALU, flag register, unified memory).

## Interface
- FLAG_W, 32: width of flag input vector
- ZERO_BIT, 0: index of ALU zero flag in `NFlag`
- OVF_BIT, 1: index of ALU overflow flag in `NFlag`
- MEM_TIMEOUT, 0: max cycles waiting for `mem_ready`; 0 = wait forever
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- funct  in  6  IR[5:0]
- NFlag  in  FLAG_W  ALU flags of current cycle
- mem_ready  in  1  memory completes request this cycle
- mem_req  out  1  memory request (fetch or data)
- IRWr  out  1  load IR from memory data
- PCWr  out  1  load PC from NPC mux
- RegDst  out  2  00 rt, 01 rd, 10 $31
- ALUSrc  out  1  0 reg B, 1 extended immediate
- Mem2Reg  out  2  00 ALU, 01 RAM, 10 PC (return address)
- RegWr  out  1  register file write enable
- MemWr  out  1  memory write (qualifies `mem_req`)
- NPCSel  out  2  00 PC+4, 01 branch target, 10 jump target, 11 register
- EXTOp  out  2  00 zero, 01 sign, 10 lui
- ALUOp  out  3  000 add, 001 sub, 010 or, 011 slt
- FlagOp  out  2  00 none, 01 set overflow flag
- retire  out  1  one-cycle pulse when an instruction completes
- illegal  out  1  one-cycle pulse on undecodable instruction
- bus_err  out  1  one-cycle pulse on memory timeout
- state  out  3  current state (debug)

## Operation
- Decoded opcodes: SPECIAL 000000 {addu 100001, subu 100011, slt 101010, jr 001000, nop 000000}, ori 001101, lw 100011, sw 101011, beq 000100, lui 001111, j 000010, jal 000011, addi 001000, addiu 001001.
- States (`state` encoding): FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4.
- FETCH: `mem_req`=1, NPCSel=00, ALUOp add. When `mem_ready`=1: IRWr=1, PCWr=1 (PC←PC+4), go to DECODE. Otherwise stay.
- DECODE: latch instruction class into an internal register.
  - j: PCWr, NPCSel=10, retire, go to FETCH.
  - jal: also RegWr, RegDst=10, Mem2Reg=10 (PC already +4).
  - jr: PCWr, NPCSel=11, retire, go to FETCH.
  - nop: retire, go to FETCH.
  - Undecodable: illegal pulse, no writes, go to FETCH.
  - All others: go to EXEC.
- EXEC: drive ALUSrc/EXTOp/ALUOp per instruction, using the single-cycle encodings.
  - beq: ALUOp sub; if `NFlag[ZERO_BIT]`=1 then PCWr with NPCSel=01; retire; go to FETCH.
  - lw/sw: go to MEM.
  - All others: latch `NFlag[OVF_BIT]` into `ovf_q`; go to WB.
- MEM: `mem_req`=1, MemWr=1 for sw. On `mem_ready`: sw retires and goes to FETCH; lw goes to WB.
- WB: RegWr=1 with the instruction's RegDst/Mem2Reg (lw: rt/RAM; R-type: rd/ALU; I-type: rt/ALU); retire; go to FETCH. addi with `ovf_q`=1: FlagOp=01.
- Default: every enable not listed for a state is 0; mux selects not listed are 00.
- Timeout: a wait counter counts cycles in FETCH/MEM with `mem_ready`=0. If MEM_TIMEOUT≠0 and the count reaches MEM_TIMEOUT: pulse bus_err, drop `mem_req`, no writes, go to FETCH. The counter clears on every state change.

## Timing
- While `rst_n`=0: state=FETCH, all outputs 0, including `mem_req`; internal class, `ovf_q` and wait counter are cleared. The first `mem_req` is in the first cycle after deassertion.
- Reset asserted mid-instruction aborts immediately; no partial writes are asserted once `rst_n` is low.
- Control outputs are combinational from state, latched class and current inputs. All transitions are registered.
- Minimum cycles with zero-wait memory: j/jr/jal/nop 2, beq 3, R/I-type 4, sw 4, lw 5. Each memory wait cycle adds 1.
- `mem_ready` is ignored outside FETCH and MEM.
- `mem_ready` arriving in the same cycle as the timeout wins: normal completion, no bus_err.

## Configuration
- `MC_CTRL_TRAP_EN` defined:
  - addi with `ovf_q`=1 in WB suppresses RegWr and asserts FlagOp=01.
  - It also asserts PCWr with NPCSel=11, steering the PC to the trap vector held on the register path.
  - retire is not pulsed.
- Not defined: addi overflow writes rd and sets the flag (FlagOp=01, RegWr=1), matching single-cycle behaviour.

## Test plan
- Reset then addu (000000/100001), `mem_ready` high every request -> states 0,1,2,4,0; WB shows RegWr=1, RegDst=01, Mem2Reg=00; retire in cycle 4.
- lw with `mem_ready` delayed 3 cycles in MEM -> `mem_req` held 4 cycles in MEM; then WB with Mem2Reg=01, RegDst=00; total 8 cycles.
- beq with NFlag[0]=1, then with NFlag[0]=0 -> PCWr=1 and NPCSel=01 in EXEC only for the first; both retire after 3 cycles.
- MEM_TIMEOUT=4, fetch with `mem_ready` low -> bus_err on the 4th wait cycle, state returns to 0, no IRWr; `mem_ready`=1 on that same cycle -> IRWr, no bus_err.
- opcode 111111 -> illegal pulse in DECODE, no RegWr/PCWr/MemWr; jal -> RegWr, RegDst=10, Mem2Reg=10, NPCSel=10 in DECODE.
- addi with NFlag[1]=1, each build -> without macro: RegWr=1, FlagOp=01; with `MC_CTRL_TRAP_EN`: RegWr=0, FlagOp=01, PCWr=1, NPCSel=11, no retire.
- rst_n pulsed low during MEM of sw -> MemWr and `mem_req` drop immediately; state=0 after release.

Source files
------------

// File: rtl/mc_controller.sv
// Multi-cycle MIPS main controller: sequences FETCH/DECODE/EXEC/MEM/WB with req/ready memory handshake.
// Optional `MC_CTRL_TRAP_EN: addi overflow traps instead of writing back.
module mc_controller #(
  parameter int          FLAG_W      = 32,
  parameter int          ZERO_BIT    = 0,
  parameter int          OVF_BIT     = 1,
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic [FLAG_W-1:0] NFlag,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              IRWr,
  output logic              PCWr,
  output logic [1:0]        RegDst,
  output logic              ALUSrc,
  output logic [1:0]        Mem2Reg,
  output logic              RegWr,
  output logic              MemWr,
  output logic [1:0]        NPCSel,
  output logic [1:0]        EXTOp,
  output logic [2:0]        ALUOp,
  output logic [1:0]        FlagOp,
  output logic              retire,
  output logic              illegal,
  output logic              bus_err,
  output logic [2:0]        state
);
  typedef enum logic [2:0] {S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_WB = 3'd4} state_t;
  typedef enum logic [3:0] {
    CL_ILL, CL_NOP, CL_ADDU, CL_SUBU, CL_SLT, CL_JR, CL_ORI, CL_LW,
    CL_SW, CL_BEQ, CL_LUI, CL_J, CL_JAL, CL_ADDI, CL_ADDIU
  } cls_t;

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_t        state_reg, state_next;
  cls_t          cls_reg, cls_d;
  logic          ovf_q;
  logic [CW-1:0] wait_cnt_reg;
  logic          mem_wait, timeout_hit, is_sw;
  logic          unused_flags;

  assign unused_flags = ^NFlag;

  function automatic cls_t decode(input logic [5:0] op, input logic [5:0] fn);
    cls_t c;
    c = CL_ILL;
    case (op)
      6'b000000:
        case (fn)
          6'b100001: c = CL_ADDU;
          6'b100011: c = CL_SUBU;
          6'b101010: c = CL_SLT;
          6'b001000: c = CL_JR;
          6'b000000: c = CL_NOP;
          default:   c = CL_ILL;
        endcase
      6'b001101: c = CL_ORI;
      6'b100011: c = CL_LW;
      6'b101011: c = CL_SW;
      6'b000100: c = CL_BEQ;
      6'b001111: c = CL_LUI;
      6'b000010: c = CL_J;
      6'b000011: c = CL_JAL;
      6'b001000: c = CL_ADDI;
      6'b001001: c = CL_ADDIU;
      default:   c = CL_ILL;
    endcase
    return c;
  endfunction

  assign cls_d    = decode(opcode, funct);
  assign is_sw    = (cls_reg == CL_SW);
  assign mem_wait = ((state_reg == S_FETCH) || (state_reg == S_MEM)) && !mem_ready;
  // Fires on the MEM_TIMEOUT-th consecutive wait cycle; a same-cycle ready never reaches here.
  assign timeout_hit = (MEM_TIMEOUT != 32'd0) && mem_wait &&
                       ((32'(wait_cnt_reg) + 32'd1) == MEM_TIMEOUT);
  assign state = state_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_FETCH;
      cls_reg      <= CL_ILL;
      ovf_q        <= 1'b0;
      wait_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_DECODE)
        cls_reg <= cls_d;
      if (state_reg == S_EXEC && cls_reg != CL_BEQ && cls_reg != CL_LW && cls_reg != CL_SW)
        ovf_q <= NFlag[OVF_BIT];
      if (state_next != state_reg || timeout_hit)
        wait_cnt_reg <= '0;
      else if (mem_wait)
        wait_cnt_reg <= wait_cnt_reg + CW'(1);
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH:  if (mem_ready) state_next = S_DECODE;
      S_DECODE:
        case (cls_d)
          CL_J, CL_JAL, CL_JR, CL_NOP, CL_ILL: state_next = S_FETCH;
          default:                             state_next = S_EXEC;
        endcase
      S_EXEC:
        case (cls_reg)
          CL_BEQ:       state_next = S_FETCH;
          CL_LW, CL_SW: state_next = S_MEM;
          default:      state_next = S_WB;
        endcase
      S_MEM:
        if (mem_ready)        state_next = is_sw ? S_FETCH : S_WB;
        else if (timeout_hit) state_next = S_FETCH;
      default:  state_next = S_FETCH;
    endcase
  end

  // Outputs are forced low while reset is held so an aborted instruction cannot write.
  always_comb begin
    mem_req = 1'b0; IRWr = 1'b0; PCWr = 1'b0; RegDst = 2'b00; ALUSrc = 1'b0;
    Mem2Reg = 2'b00; RegWr = 1'b0; MemWr = 1'b0; NPCSel = 2'b00; EXTOp = 2'b00;
    ALUOp = 3'b000; FlagOp = 2'b00; retire = 1'b0; illegal = 1'b0; bus_err = 1'b0;
    if (rst_n) begin
      case (state_reg)
        S_FETCH: begin
          mem_req = mem_ready || !timeout_hit;
          IRWr    = mem_ready;
          PCWr    = mem_ready;
          bus_err = timeout_hit;
        end
        S_DECODE:
          case (cls_d)
            CL_J:   begin PCWr = 1'b1; NPCSel = 2'b10; retire = 1'b1; end
            CL_JAL: begin
              PCWr = 1'b1; NPCSel = 2'b10; retire = 1'b1;
              RegWr = 1'b1; RegDst = 2'b10; Mem2Reg = 2'b10;
            end
            CL_JR:  begin PCWr = 1'b1; NPCSel = 2'b11; retire = 1'b1; end
            CL_NOP: retire = 1'b1;
            CL_ILL: illegal = 1'b1;
            default: ;
          endcase
        S_EXEC:
          case (cls_reg)
            CL_SUBU: ALUOp = 3'b001;
            CL_SLT:  ALUOp = 3'b011;
            CL_ORI:  begin ALUSrc = 1'b1; ALUOp = 3'b010; end
            CL_LUI:  begin ALUSrc = 1'b1; EXTOp = 2'b10; ALUOp = 3'b010; end
            CL_LW, CL_SW, CL_ADDI, CL_ADDIU: begin ALUSrc = 1'b1; EXTOp = 2'b01; end
            CL_BEQ: begin
              ALUOp  = 3'b001;
              PCWr   = NFlag[ZERO_BIT];
              NPCSel = NFlag[ZERO_BIT] ? 2'b01 : 2'b00;
              retire = 1'b1;
            end
            default: ;
          endcase
        S_MEM: begin
          mem_req = mem_ready || !timeout_hit;
          MemWr   = is_sw && mem_req;
          retire  = is_sw && mem_ready;
          bus_err = timeout_hit;
        end
        S_WB: begin
          RegWr  = 1'b1;
          retire = 1'b1;
          case (cls_reg)
            CL_LW:                   Mem2Reg = 2'b01;
            CL_ADDU, CL_SUBU, CL_SLT: RegDst = 2'b01;
            default: ;
          endcase
          if (cls_reg == CL_ADDI && ovf_q) begin
            FlagOp = 2'b01;
`ifdef MC_CTRL_TRAP_EN
            RegWr  = 1'b0;
            retire = 1'b0;
            PCWr   = 1'b1;
            NPCSel = 2'b11;
`endif
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller (MEM_TIMEOUT=4); checks every control output each step.
module tb_mc_controller;
  logic        clk, rst_n, mem_ready;
  logic [5:0]  opcode, funct;
  logic [31:0] NFlag;
  logic        mem_req, IRWr, PCWr, ALUSrc, RegWr, MemWr, retire, illegal, bus_err;
  logic [1:0]  RegDst, Mem2Reg, NPCSel, EXTOp, FlagOp;
  logic [2:0]  ALUOp, state;

  typedef struct packed {
    logic       mem_req, irwr, pcwr;
    logic [1:0] regdst;
    logic       alusrc;
    logic [1:0] mem2reg;
    logic       regwr, memwr;
    logic [1:0] npcsel, extop;
    logic [2:0] aluop;
    logic [1:0] flagop;
    logic       retire, illegal, bus_err;
    logic [2:0] state;
  } ctl_t;

  int   checks = 0;
  int   errors = 0;
  ctl_t e;

  mc_controller #(.FLAG_W(32), .ZERO_BIT(0), .OVF_BIT(1), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .NFlag(NFlag),
    .mem_ready(mem_ready), .mem_req(mem_req), .IRWr(IRWr), .PCWr(PCWr),
    .RegDst(RegDst), .ALUSrc(ALUSrc), .Mem2Reg(Mem2Reg), .RegWr(RegWr),
    .MemWr(MemWr), .NPCSel(NPCSel), .EXTOp(EXTOp), .ALUOp(ALUOp),
    .FlagOp(FlagOp), .retire(retire), .illegal(illegal), .bus_err(bus_err),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ctl_t st(input logic [2:0] s);
    ctl_t c;
    c = '0;
    c.state = s;
    return c;
  endfunction

  task automatic cmp(input string tag, input ctl_t exp_c);
    ctl_t o;
    o = {mem_req, IRWr, PCWr, RegDst, ALUSrc, Mem2Reg, RegWr, MemWr,
         NPCSel, EXTOp, ALUOp, FlagOp, retire, illegal, bus_err, state};
    checks++;
    assert (o === exp_c) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, exp_c);
    end
  endtask

  task automatic fetch_ok(input string tag, input logic [5:0] op, input logic [5:0] fn);
    ctl_t c;
    @(negedge clk);
    opcode = op; funct = fn; mem_ready = 1'b1;
    #1;
    c = st(3'd0); c.mem_req = 1'b1; c.irwr = 1'b1; c.pcwr = 1'b1;
    cmp(tag, c);
  endtask

  task automatic decode_plain(input string tag);
    @(negedge clk); #1;
    cmp(tag, st(3'd1));
  endtask

  task automatic exec_imm(input string tag);
    ctl_t c;
    @(negedge clk); #1;
    c = st(3'd2); c.alusrc = 1'b1; c.extop = 2'b01;
    cmp(tag, c);
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b1; opcode = '0; funct = '0; NFlag = '0;
    repeat (2) @(negedge clk);
    #1 cmp("reset", st(3'd0));

    // addu, zero-wait memory
    @(negedge clk);
    rst_n = 1'b1; opcode = 6'b000000; funct = 6'b100001; mem_ready = 1'b1;
    #1; e = st(3'd0); e.mem_req = 1'b1; e.irwr = 1'b1; e.pcwr = 1'b1; cmp("addu_fetch", e);
    decode_plain("addu_decode");
    @(negedge clk); #1; cmp("addu_exec", st(3'd2));
    @(negedge clk); #1;
    e = st(3'd4); e.regwr = 1'b1; e.regdst = 2'b01; e.retire = 1'b1; cmp("addu_wb", e);
    $display("txn addu");

    // lw with three MEM wait cycles
    fetch_ok("lw_fetch", 6'b100011, 6'b000000);
    decode_plain("lw_decode");
    exec_imm("lw_exec");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); mem_ready = 1'b0; #1;
      e = st(3'd3); e.mem_req = 1'b1; cmp("lw_mem_wait", e);
    end
    @(negedge clk); mem_ready = 1'b1; #1;
    e = st(3'd3); e.mem_req = 1'b1; cmp("lw_mem_ready", e);
    @(negedge clk); #1;
    e = st(3'd4); e.regwr = 1'b1; e.mem2reg = 2'b01; e.retire = 1'b1; cmp("lw_wb", e);
    $display("txn lw");

    // beq taken then not taken
    fetch_ok("beq1_fetch", 6'b000100, 6'b000000);
    decode_plain("beq1_decode");
    @(negedge clk); NFlag = 32'h1; #1;
    e = st(3'd2); e.aluop = 3'b001; e.pcwr = 1'b1; e.npcsel = 2'b01; e.retire = 1'b1;
    cmp("beq_taken_exec", e);
    fetch_ok("beq2_fetch", 6'b000100, 6'b000000);
    decode_plain("beq2_decode");
    @(negedge clk); NFlag = 32'h0; #1;
    e = st(3'd2); e.aluop = 3'b001; e.retire = 1'b1; cmp("beq_nottaken_exec", e);
    $display("txn beq x2");

    // fetch timeout after 4 wait cycles, then ready racing the timeout
    @(negedge clk); mem_ready = 1'b0; opcode = 6'b111111; funct = 6'b000000; #1;
    e = st(3'd0); e.mem_req = 1'b1; cmp("to_wait1", e);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1; cmp("to_wait", e);
    end
    @(negedge clk); #1;
    e = st(3'd0); e.bus_err = 1'b1; cmp("to_bus_err", e);
    @(negedge clk); #1;
    e = st(3'd0); e.mem_req = 1'b1; cmp("to_refetch", e);
    repeat (2) @(negedge clk);
    @(negedge clk); mem_ready = 1'b1; #1;
    e = st(3'd0); e.mem_req = 1'b1; e.irwr = 1'b1; e.pcwr = 1'b1; cmp("to_race_ready", e);
    @(negedge clk); #1;
    e = st(3'd1); e.illegal = 1'b1; cmp("illegal_decode", e);
    $display("txn timeout+illegal");

    // jal and jr finish in DECODE
    fetch_ok("jal_fetch", 6'b000011, 6'b000000);
    @(negedge clk); #1;
    e = st(3'd1); e.pcwr = 1'b1; e.npcsel = 2'b10; e.regwr = 1'b1;
    e.regdst = 2'b10; e.mem2reg = 2'b10; e.retire = 1'b1; cmp("jal_decode", e);
    fetch_ok("jr_fetch", 6'b000000, 6'b001000);
    @(negedge clk); #1;
    e = st(3'd1); e.pcwr = 1'b1; e.npcsel = 2'b11; e.retire = 1'b1; cmp("jr_decode", e);
    $display("txn jal jr");

    // addi overflowing
    fetch_ok("addi_fetch", 6'b001000, 6'b000000);
    decode_plain("addi_decode");
    @(negedge clk); NFlag = 32'h2; #1;
    e = st(3'd2); e.alusrc = 1'b1; e.extop = 2'b01; cmp("addi_exec", e);
    @(negedge clk); NFlag = 32'h0; #1;
`ifdef MC_CTRL_TRAP_EN
    e = st(3'd4); e.flagop = 2'b01; e.pcwr = 1'b1; e.npcsel = 2'b11;
`else
    e = st(3'd4); e.flagop = 2'b01; e.regwr = 1'b1; e.retire = 1'b1;
`endif
    cmp("addi_ovf_wb", e);
    $display("txn addi ovf");

    // sw interrupted by reset in MEM
    fetch_ok("sw_fetch", 6'b101011, 6'b000000);
    decode_plain("sw_decode");
    exec_imm("sw_exec");
    @(negedge clk); mem_ready = 1'b0; #1;
    e = st(3'd3); e.mem_req = 1'b1; e.memwr = 1'b1; cmp("sw_mem_wait", e);
    #2 rst_n = 1'b0;
    #1 cmp("sw_reset_abort", st(3'd0));
    @(negedge clk); rst_n = 1'b1; #1;
    e = st(3'd0); e.mem_req = 1'b1; cmp("post_reset_fetch", e);
    $display("txn sw reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
